// File: rtl/sonar_pkg.sv
// sonar_pkg: state encodings, sweep directions and default timing shared by the sonar sequencer.
package sonar_pkg;
  localparam int CLK_HZ = 50_000_000;
  localparam int T_ASSENTA_PADRAO = CLK_HZ / 5;
  localparam int T_TIMEOUT_PADRAO = CLK_HZ / 20;
  typedef enum logic [3:0] {
    INICIAL     = 4'd0,
    POSICIONA   = 4'd1,
    MEDE        = 4'd2,
    AGUARDA_MED = 4'd3,
    TRANSMITE   = 4'd4,
    AGUARDA_TX  = 4'd5,
    FIM_POS     = 4'd6
  } estado_t;
  localparam logic SOBE  = 1'b0;
  localparam logic DESCE = 1'b1;
endpackage

// File: rtl/contador_temporizador.sv
// contador_temporizador: saturating up-counter with synchronous clear and a terminal-value flag.
module contador_temporizador #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         limpa,
  input  logic         conta,
  input  logic [W-1:0] limite,
  output logic         fim
);
  logic [W-1:0] cont_q, cont_d;
  assign fim = cont_q == limite;
  always_comb cont_d = limpa ? '0 : (conta && !fim) ? cont_q + W'(1) : cont_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cont_q <= '0;
    else cont_q <= cont_d;
endmodule

// File: rtl/sonar_sequenciador.sv
// sonar_sequenciador: ping-pong servo sweep; at each position settle, measure, transmit, then pulse fim_posicao.
module sonar_sequenciador
  import sonar_pkg::*;
#(
  parameter int N_POSICOES = 8,
  parameter int T_ASSENTA  = T_ASSENTA_PADRAO,
  parameter int T_TIMEOUT  = T_TIMEOUT_PADRAO,
  parameter int W_CONT     = 24
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ligar,
  input  logic       medida_pronto,
  input  logic       tx_pronto,
  output logic       medir,
  output logic       transmitir,
  output logic [3:0] posicao,
  output logic       fim_posicao,
  output logic       erro_timeout,
  output logic [3:0] db_estado
);
  localparam logic [3:0] ULTIMA = 4'(N_POSICOES - 1);
  estado_t    estado_q, estado_d;
  logic [3:0] posicao_q, posicao_d;
  logic       dir_q, dir_d, erro_q, erro_d;
  logic       medir_q, transmitir_q, fim_q, fim_t, vira;
  // One timer serves both waits; it restarts on every state change.
  contador_temporizador #(.W(W_CONT)) u_temporizador (
    .clk   (clock),
    .rst_n (reset),
    .limpa (estado_d != estado_q),
    .conta (estado_q == POSICIONA || estado_q == AGUARDA_MED),
    .limite(estado_q == AGUARDA_MED ? W_CONT'(T_TIMEOUT - 1) : W_CONT'(T_ASSENTA - 1)),
    .fim   (fim_t)
  );
  assign vira = (dir_q == SOBE) ? posicao_q == ULTIMA : posicao_q == 4'd0;
  always_comb begin
    estado_d  = INICIAL;
    posicao_d = posicao_q;
    dir_d     = dir_q;
    erro_d    = erro_q;
    case (estado_q)
      INICIAL:     estado_d = ligar ? POSICIONA : INICIAL;
      POSICIONA:   estado_d = fim_t ? MEDE : POSICIONA;
      MEDE:        estado_d = AGUARDA_MED;
      AGUARDA_MED: begin
        estado_d = medida_pronto ? TRANSMITE : fim_t ? FIM_POS : AGUARDA_MED;
        erro_d   = medida_pronto ? 1'b0 : fim_t ? 1'b1 : erro_q;
      end
      TRANSMITE:   estado_d = AGUARDA_TX;
      AGUARDA_TX:  estado_d = tx_pronto ? FIM_POS : AGUARDA_TX;
      FIM_POS: begin
        estado_d  = ligar ? POSICIONA : INICIAL;
        dir_d     = vira ? ~dir_q : dir_q;
        posicao_d = (dir_d == DESCE) ? posicao_q - 4'd1 : posicao_q + 4'd1;
      end
      default:     estado_d = INICIAL;
    endcase
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      estado_q     <= INICIAL;
      posicao_q    <= 4'd0;
      dir_q        <= SOBE;
      erro_q       <= 1'b0;
      medir_q      <= 1'b0;
      transmitir_q <= 1'b0;
      fim_q        <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      posicao_q    <= posicao_d;
      dir_q        <= dir_d;
      erro_q       <= erro_d;
      medir_q      <= estado_q == MEDE;
      transmitir_q <= estado_q == TRANSMITE;
      fim_q        <= estado_q == FIM_POS;
    end
  assign medir        = medir_q;
  assign transmitir   = transmitir_q;
  assign fim_posicao  = fim_q;
  assign posicao      = posicao_q;
  assign erro_timeout = erro_q;
  assign db_estado    = estado_q;
endmodule

// File: tb/tb_sonar_sequenciador.sv
// tb_sonar_sequenciador: scenario tasks with randomized response delays against a sweep/latency model.
module tb_sonar_sequenciador;
  localparam int N  = 4;
  localparam int TA = 100;
  localparam int TT = 1000;
  logic       clock = 1'b0, reset = 1'b0, ligar = 1'b0, medida_pronto = 1'b0, tx_pronto = 1'b0;
  logic       medir, transmitir, fim_posicao, erro_timeout;
  logic [3:0] posicao, db_estado;
  int passed = 0, total = 0, k = 0;
  int cnt_medir = 0, cnt_tx = 0, cnt_fim = 0;

  sonar_sequenciador #(.N_POSICOES(N), .T_ASSENTA(TA), .T_TIMEOUT(TT), .W_CONT(24)) dut (
    .clock(clock), .reset(reset), .ligar(ligar), .medida_pronto(medida_pronto),
    .tx_pronto(tx_pronto), .medir(medir), .transmitir(transmitir), .posicao(posicao),
    .fim_posicao(fim_posicao), .erro_timeout(erro_timeout), .db_estado(db_estado));

  always #10 clock = ~clock;
  always @(negedge clock) begin
    if (medir) cnt_medir++;
    if (transmitir) cnt_tx++;
    if (fim_posicao) cnt_fim++;
  end

  // k-th visited position of a ping-pong sweep over N positions (period 2N-2).
  function automatic int pos_modelo(input int idx);
    int p = idx % (2 * (N - 1));
    return (p < N) ? p : 2 * (N - 1) - p;
  endfunction

  task automatic ciclo(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic ciclos_ate(input int sel, input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      @(posedge clock); #1;
      if ((sel == 0 && medir) || (sel == 1 && transmitir) || (sel == 2 && fim_posicao)) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic roda_posicao(input int d_med, input int d_tx, output int lat_tx, output int lat_fim);
    int n;
    ciclo(d_med - 1);
    medida_pronto = 1'b1; ciclo(1); medida_pronto = 1'b0;
    ciclos_ate(1, 10, n);
    lat_tx = (n < 0) ? n : n + 1;
    ciclo(d_tx - 1);
    tx_pronto = 1'b1; ciclo(1); tx_pronto = 1'b0;
    ciclos_ate(2, 10, n);
    lat_fim = (n < 0) ? n : n + 1;
  endtask

  task automatic test_reset;
    int n;
    ligar = 1'b1; reset = 1'b0;
    #2000;
    total++; if (medir !== 1'b0) $display("FAIL reset_medir: got %b expected 0", medir); else passed++;
    total++; if (transmitir !== 1'b0) $display("FAIL reset_transmitir: got %b expected 0", transmitir); else passed++;
    total++; if (fim_posicao !== 1'b0) $display("FAIL reset_fim: got %b expected 0", fim_posicao); else passed++;
    total++; if (erro_timeout !== 1'b0) $display("FAIL reset_erro: got %b expected 0", erro_timeout); else passed++;
    total++; if (posicao !== 4'd0) $display("FAIL reset_posicao: got %0d expected 0", posicao); else passed++;
    total++; if (db_estado !== 4'd0) $display("FAIL reset_estado: got %0d expected 0", db_estado); else passed++;
    @(posedge clock); #1; reset = 1'b1;
    ciclos_ate(0, 300, n);
    total++; if (n != TA + 2) $display("FAIL reset_lat_medir: got %0d expected %0d", n, TA + 2); else passed++;
    k = 0;
  endtask

  task automatic test_normal;
    int lt, lf;
    roda_posicao(50, 200, lt, lf);
    k++;
    total++; if (lt != 2) $display("FAIL normal_lat_tx: got %0d expected 2", lt); else passed++;
    total++; if (lf != 2) $display("FAIL normal_lat_fim: got %0d expected 2", lf); else passed++;
    total++; if (posicao !== 4'(pos_modelo(k))) $display("FAIL normal_posicao: got %0d expected %0d", posicao, pos_modelo(k)); else passed++;
    total++; if (erro_timeout !== 1'b0) $display("FAIL normal_erro: got %b expected 0", erro_timeout); else passed++;
  endtask

  task automatic test_full_sweep;
    int n, lt, lf, m0, f0;
    reset = 1'b0; ligar = 1'b1;
    #100;
    m0 = cnt_medir; f0 = cnt_fim;
    @(posedge clock); #1; reset = 1'b1;
    k = 0;
    ciclos_ate(0, 300, n);
    total++; if (n != TA + 2) $display("FAIL sweep_lat_inicio: got %0d expected %0d", n, TA + 2); else passed++;
    for (int i = 0; i < 8; i++) begin
      total++; if (posicao !== 4'(pos_modelo(k))) $display("FAIL sweep_posicao[%0d]: got %0d expected %0d", i, posicao, pos_modelo(k)); else passed++;
      ciclo(1);
      total++; if (medir !== 1'b0) $display("FAIL sweep_medir_largura[%0d]: got %b expected 0", i, medir); else passed++;
      if (i == 7) ligar = 1'b0;
      roda_posicao($urandom_range(1, 300), $urandom_range(1, 300), lt, lf);
      k++;
      total++; if (lt != 2) $display("FAIL sweep_lat_tx[%0d]: got %0d expected 2", i, lt); else passed++;
      total++; if (lf != 2) $display("FAIL sweep_lat_fim[%0d]: got %0d expected 2", i, lf); else passed++;
      if (i < 7) begin
        ciclos_ate(0, 300, n);
        total++; if (n != TA + 1) $display("FAIL sweep_lat_medir[%0d]: got %0d expected %0d", i, n, TA + 1); else passed++;
      end
    end
    ciclo(3);
    total++; if (db_estado !== 4'd0) $display("FAIL sweep_parado: got %0d expected 0", db_estado); else passed++;
    total++; if (cnt_medir - m0 != 8) $display("FAIL sweep_n_medir: got %0d expected 8", cnt_medir - m0); else passed++;
    total++; if (cnt_fim - f0 != 8) $display("FAIL sweep_n_fim: got %0d expected 8", cnt_fim - f0); else passed++;
    total++; if (posicao !== 4'(pos_modelo(k))) $display("FAIL sweep_posicao_final: got %0d expected %0d", posicao, pos_modelo(k)); else passed++;
  endtask

  task automatic test_timeout;
    int n, lt, lf, t0;
    ligar = 1'b1;
    ciclos_ate(0, 300, n);
    total++; if (n != TA + 2) $display("FAIL timeout_lat_medir: got %0d expected %0d", n, TA + 2); else passed++;
    t0 = cnt_tx;
    ciclos_ate(2, TT + 50, n);
    k++;
    total++; if (n != TT + 1) $display("FAIL timeout_lat_fim: got %0d expected %0d", n, TT + 1); else passed++;
    total++; if (erro_timeout !== 1'b1) $display("FAIL timeout_erro: got %b expected 1", erro_timeout); else passed++;
    total++; if (cnt_tx != t0) $display("FAIL timeout_sem_tx: got %0d expected %0d", cnt_tx, t0); else passed++;
    total++; if (posicao !== 4'(pos_modelo(k))) $display("FAIL timeout_posicao: got %0d expected %0d", posicao, pos_modelo(k)); else passed++;
    ciclos_ate(0, 300, n);
    total++; if (n != TA + 1) $display("FAIL timeout_lat_prox: got %0d expected %0d", n, TA + 1); else passed++;
    roda_posicao($urandom_range(1, 300), $urandom_range(1, 300), lt, lf);
    k++;
    total++; if (lt != 2) $display("FAIL timeout_prox_lat_tx: got %0d expected 2", lt); else passed++;
    total++; if (erro_timeout !== 1'b0) $display("FAIL timeout_erro_limpo: got %b expected 0", erro_timeout); else passed++;
  endtask

  task automatic test_ligar_off;
    int n, f0;
    ciclos_ate(0, 300, n);
    total++; if (n != TA + 1) $display("FAIL off_lat_medir: got %0d expected %0d", n, TA + 1); else passed++;
    total++; if (posicao !== 4'(pos_modelo(k))) $display("FAIL off_posicao: got %0d expected %0d", posicao, pos_modelo(k)); else passed++;
    ciclo($urandom_range(0, 200));
    medida_pronto = 1'b1; ciclo(1); medida_pronto = 1'b0;
    ciclos_ate(1, 10, n);
    ligar = 1'b0;
    ciclo($urandom_range(0, 200));
    f0 = cnt_fim;
    tx_pronto = 1'b1; ciclo(1); tx_pronto = 1'b0;
    ciclos_ate(2, 10, n);
    k++;
    total++; if (n + 1 != 2) $display("FAIL off_lat_fim: got %0d expected 2", n + 1); else passed++;
    ciclo(20);
    total++; if (db_estado !== 4'd0) $display("FAIL off_parado: got %0d expected 0", db_estado); else passed++;
    total++; if (cnt_fim - f0 != 1) $display("FAIL off_n_fim: got %0d expected 1", cnt_fim - f0); else passed++;
    ligar = 1'b1;
    ciclos_ate(0, 300, n);
    total++; if (n != TA + 2) $display("FAIL off_retoma_lat: got %0d expected %0d", n, TA + 2); else passed++;
    total++; if (posicao !== 4'(pos_modelo(k))) $display("FAIL off_retoma_posicao: got %0d expected %0d", posicao, pos_modelo(k)); else passed++;
  endtask

  task automatic test_async_reset;
    int n, t0;
    ciclo(30);
    #7 reset = 1'b0;
    #1;
    total++; if (db_estado !== 4'd0) $display("FAIL areset_estado: got %0d expected 0", db_estado); else passed++;
    total++; if (posicao !== 4'd0) $display("FAIL areset_posicao: got %0d expected 0", posicao); else passed++;
    total++; if (erro_timeout !== 1'b0) $display("FAIL areset_erro: got %b expected 0", erro_timeout); else passed++;
    ligar = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    t0 = cnt_tx;
    medida_pronto = 1'b1; ciclo(1); medida_pronto = 1'b0;
    ciclo(10);
    total++; if (db_estado !== 4'd0) $display("FAIL areset_medida_tardia: got %0d expected 0", db_estado); else passed++;
    total++; if (cnt_tx != t0) $display("FAIL areset_sem_tx: got %0d expected %0d", cnt_tx, t0); else passed++;
    ligar = 1'b1;
    ciclos_ate(0, 300, n);
    total++; if (n != TA + 2) $display("FAIL areset_lat_medir: got %0d expected %0d", n, TA + 2); else passed++;
    total++; if (posicao !== 4'd0) $display("FAIL areset_reinicio: got %0d expected 0", posicao); else passed++;
    ligar = 1'b0;
  endtask

  initial begin
    test_reset;
    test_normal;
    test_full_sweep;
    test_timeout;
    test_ligar_off;
    test_async_reset;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
